// File: rtl/ide_pio_cycle_sequencer.sv
// ---------------------------------------------------------------------------
// ide_pio_cycle_sequencer
//
// Device-side stage behind the XT-to-IDE bridge. The bridge presents IDE
// strobes as levels for as long as the host cycle lasts. This block turns
// each request into one timed ATA PIO cycle (setup, active, IORDY wait,
// recovery). It holds the XT bus through io_ready for the whole device
// cycle and latches the 16-bit read data for the bridge.
//
// Ports
//   clock, reset          system clock, synchronous active-high reset
//   ide_cs1fx/ide_cs3fx   bridge chip selects (active low)
//   ide_io_read_n/_write_n bridge level strobes (active low)
//   ide_address           bridge register address
//   ide_data_bus_out      bridge write data
//   ide_data_bus_in       latched device read data back to the bridge
//   io_ready              XT I/O channel ready (0 stretches the host cycle)
//   dev_cs0_n/dev_cs1_n   ATA chip selects
//   dev_da                ATA register address
//   dev_dior_n/dev_diow_n ATA read/write strobes
//   dev_dd_out/dev_dd_oe  ATA write data and its output enable
//   dev_dd_in             ATA read data
//   dev_iordy             ATA IORDY (1 = ready)
//   timeout               sticky IORDY timeout flag, cleared only by reset
// ---------------------------------------------------------------------------
module ide_pio_cycle_sequencer #(
    parameter int SETUP_CYCLES    = 2,
    parameter int ACTIVE_CYCLES   = 6,
    parameter int RECOVERY_CYCLES = 3,
    parameter int IORDY_TIMEOUT   = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ide_cs1fx,
    input  logic        ide_cs3fx,
    input  logic        ide_io_read_n,
    input  logic        ide_io_write_n,
    input  logic [2:0]  ide_address,
    input  logic [15:0] ide_data_bus_out,
    output logic [15:0] ide_data_bus_in,
    output logic        io_ready,
    output logic        dev_cs0_n,
    output logic        dev_cs1_n,
    output logic [2:0]  dev_da,
    output logic        dev_dior_n,
    output logic        dev_diow_n,
    output logic [15:0] dev_dd_out,
    output logic        dev_dd_oe,
    input  logic [15:0] dev_dd_in,
    input  logic        dev_iordy,
    output logic        timeout
);

    localparam int MAX_SA  = (SETUP_CYCLES > ACTIVE_CYCLES) ? SETUP_CYCLES : ACTIVE_CYCLES;
    localparam int MAX_RT  = (RECOVERY_CYCLES > IORDY_TIMEOUT) ? RECOVERY_CYCLES : IORDY_TIMEOUT;
    localparam int MAX_ALL = (MAX_SA > MAX_RT) ? MAX_SA : MAX_RT;
    localparam int CW      = (MAX_ALL < 1) ? 1 : $clog2(MAX_ALL + 1);

    // Counters count down to zero, so each state loads its length minus one.
    localparam logic [CW-1:0] LD_SETUP = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] LD_ACT   = CW'(ACTIVE_CYCLES - 1);
    localparam logic [CW-1:0] LD_REC   = CW'(RECOVERY_CYCLES - 1);
    localparam logic [CW-1:0] LD_TO    = CW'(IORDY_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_ACTIVE  = 3'd2,
        S_RECOVER = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_wait;     // minimum active time served, now waiting on IORDY
    logic          r_is_read;
    logic          w_req;
    logic          w_exit;     // active phase ends on this edge
    logic          w_to;       // ...and it ends because IORDY never came

    // A request needs a chip select and exactly one strobe; both strobes low is ignored.
    assign w_req = (~ide_cs1fx | ~ide_cs3fx) & (ide_io_read_n ^ ide_io_write_n);

    // Decide whether the active phase ends now, and whether that end is a timeout.
    always_comb begin
        w_exit = 1'b0;
        w_to   = 1'b0;
        if (r_state == S_ACTIVE) begin
            if (r_wait) begin
                if (dev_iordy) begin
                    w_exit = 1'b1;
                end else if (r_cnt == '0) begin
                    w_exit = 1'b1;
                    w_to   = 1'b1;
                end else begin
                    w_exit = 1'b0;
                end
            end else if (r_cnt == '0) begin
                if (dev_iordy) begin
                    w_exit = 1'b1;
                end else if (IORDY_TIMEOUT == 0) begin
                    w_exit = 1'b1;
                    w_to   = 1'b1;
                end else begin
                    w_exit = 1'b0;
                end
            end else begin
                w_exit = 1'b0;
            end
        end else begin
            w_exit = 1'b0;
        end
    end

    // Cycle sequencer; every device-facing output is driven from here as a register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_cnt           <= '0;
            r_wait          <= 1'b0;
            r_is_read       <= 1'b0;
            dev_cs0_n       <= 1'b1;
            dev_cs1_n       <= 1'b1;
            dev_da          <= 3'd0;
            dev_dior_n      <= 1'b1;
            dev_diow_n      <= 1'b1;
            dev_dd_oe       <= 1'b0;
            dev_dd_out      <= 16'hFFFF;
            ide_data_bus_in <= 16'hFFFF;
            io_ready        <= 1'b1;
            timeout         <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_is_read <= ~ide_io_read_n;
                        dev_cs0_n <= ide_cs1fx;
                        dev_cs1_n <= ide_cs3fx;
                        dev_da    <= ide_address;
                        dev_dd_oe <= ~ide_io_write_n;
                        if (~ide_io_write_n) begin
                            dev_dd_out <= ide_data_bus_out;
                        end
                        io_ready  <= 1'b0;
                        r_cnt     <= LD_SETUP;
                        r_state   <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (r_cnt == '0) begin
                        if (r_is_read) begin
                            dev_dior_n <= 1'b0;
                        end else begin
                            dev_diow_n <= 1'b0;
                        end
                        r_wait  <= 1'b0;
                        r_cnt   <= LD_ACT;
                        r_state <= S_ACTIVE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_ACTIVE: begin
                    if (w_exit) begin
                        dev_dior_n <= 1'b1;
                        dev_diow_n <= 1'b1;
                        if (r_is_read) begin
                            // A timed-out read returns all ones rather than bus garbage.
                            ide_data_bus_in <= w_to ? 16'hFFFF : dev_dd_in;
                        end
                        if (w_to) begin
                            timeout <= 1'b1;
                        end
                        r_wait  <= 1'b0;
                        r_cnt   <= LD_REC;
                        r_state <= S_RECOVER;
                    end else if (!r_wait && (r_cnt == '0)) begin
                        r_wait <= 1'b1;
                        r_cnt  <= LD_TO;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_RECOVER: begin
                    if (r_cnt == '0) begin
                        dev_cs0_n <= 1'b1;
                        dev_cs1_n <= 1'b1;
                        dev_dd_oe <= 1'b0;
                        io_ready  <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_DONE: begin
                    // Wait for the host to end its cycle so one request makes one device cycle.
                    if (ide_io_read_n && ide_io_write_n) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
